operand_fetch_arbiter: RTL and testbench
========================================

Name: operand_fetch_arbiter

Overview:
- Shares the register file's single pair of read-port selects among N_REQ requesters (decode, debug, interrupt save).
- Typical requesters need a register read while the pipeline stalls.
- Arbitrates, drives sel0/sel1 into the 8-to-2 read multiplexer, captures its Q0/Q1 outputs, and returns them with a valid/ready response.
- Sits between the register file and the control/decode logic; one read transaction is in flight at a time.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_W, 16, register data width.
- ADDR_W, 3, register index width; the index value equals the mux select code (000 selects R0/H input, 111 selects R7/A input).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  per-requester read request (level).
- req_addr0  input  N_REQ*ADDR_W  port-0 register index; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_addr1  input  N_REQ*ADDR_W  port-1 register index, same packing.
- gnt  output  N_REQ  registered one-hot grant, one-cycle pulse.
- sel0  output  ADDR_W  select for mux Q0.
- sel1  output  ADDR_W  select for mux Q1.
- rf_q0  input  DATA_W  from mux Q0.
- rf_q1  input  DATA_W  from mux Q1.
- rsp_valid  output  1  response data valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  clog2(N_REQ)  index of the served requester.
- rsp_data0  output  DATA_W  captured Q0.
- rsp_data1  output  DATA_W  captured Q1.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values (async, immediate): state=IDLE, gnt=0, sel0=sel1=0, rsp_valid=0, rsp_id=0, rsp_data0=rsp_data1=0, rr pointer=0.
- States are IDLE, READ and HOLD.
- IDLE:
  - If req is nonzero, pick winner W at the clock edge.
  - Latch sel0/sel1 from W's addresses.
  - Set gnt[W]=1 and rsp_id=W, then go to READ.
  - If req is zero, stay in IDLE; sel holds its last value.
- READ (one cycle):
  - gnt is high for this cycle only; sel is stable.
  - At the edge, capture rsp_data0<=rf_q0 and rsp_data1<=rf_q1, set rsp_valid=1, go to HOLD.
- HOLD:
  - rsp_valid and the data are held stable until rsp_valid&rsp_ready at an edge.
  - At that edge, clear rsp_valid, advance the rr pointer to W+1 (mod N_REQ), and go to IDLE.
- Latency: request seen in cycle 0 → gnt in cycle 1 → rsp_valid in cycle 2. With rsp_ready tied high, throughput is one read per 3 cycles.
- Requester contract:
  - Hold req and the addresses stable until gnt; deassert req in the cycle after gnt.
  - Addresses are sampled only at the IDLE→READ edge; later changes are ignored.
- Requests arriving during READ/HOLD wait; they are never dropped and never pre-empt the transaction in flight.
- sel0==sel1 is legal; both data outputs then carry the same register.
- rsp_ready while rsp_valid=0 is ignored.
- rst asserted mid-transaction aborts it: no rsp_valid is produced and the pointer returns to 0.

Optional Feature:
- OFA_ROUND_ROBIN_EN defined: rotating priority. Search starts at the rr pointer, so a continuously requesting client waits at most N_REQ-1 transactions.
- Not defined: fixed priority, lowest index wins; the rr pointer is removed and fairness is not guaranteed.

Decomposition:
- Shared package/header ofa_pkg holds the state encodings (IDLE=2'd0, READ=2'd1, HOLD=2'd2) and the ADDR_W/DATA_W defaults.
- One sub-module, rr_arbiter: combinational one-hot pick from req and the pointer, plus the encoded index.
  - It honours OFA_ROUND_ROBIN_EN.
  - The FSM and capture registers stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with req=3'b111 → all outputs 0 immediately, busy=0, no gnt while rst is high.
- Single read: R3=16'h1234, R5=16'hABCD, req[1] with addr0=3, addr1=5, rsp_ready=1 → gnt=3'b010 at cycle 1, sel0=3/sel1=5, rsp_valid at cycle 2 with data 1234/ABCD, rsp_id=1.
- Backpressure: rsp_ready=0 for 4 cycles after rsp_valid, with rf_q0 changing → rsp_data0 stays 16'h1234 and busy=1; accepted on the cycle ready rises, then IDLE.
- Contention, OFA_ROUND_ROBIN_EN on: req=3'b111 held, re-raised after each gnt → grant order 0,1,2,0.
- Contention, macro off → grant order 0,0,0; req[2] is starved.
- Same register on both ports: addr0=addr1=7, R7=16'hFFFF → rsp_data0=rsp_data1=16'hFFFF.
- Abort: rst pulse during HOLD → rsp_valid drops asynchronously; the next req is served with fresh data and rsp_id from pointer 0.

Source files
------------

// File: rtl/ofa_pkg.sv
// Shared definitions for the operand fetch arbiter: FSM state
// encodings and default widths.
package ofa_pkg;

    localparam int OFA_N_REQ  = 3;
    localparam int OFA_DATA_W = 16;
    localparam int OFA_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } ofa_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester pick: one-hot grant plus encoded index.
// OFA_ROUND_ROBIN_EN: search starts at ptr; otherwise lowest index wins.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
`ifdef OFA_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]  ptr,
`endif
    output logic [N_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]  idx
);

    logic found;

    // First requesting index in priority order wins
    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        found  = 1'b0;
`ifdef OFA_ROUND_ROBIN_EN
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = ID_W'(k);
            end
        end
`endif
        if (found) gnt_oh[idx] = 1'b1;
    end

endmodule

// File: rtl/operand_fetch_arbiter.sv
// Shares the register file read selects among N_REQ requesters.
// Optional OFA_ROUND_ROBIN_EN enables rotating priority.
module operand_fetch_arbiter
    import ofa_pkg::*;
#(
    parameter int N_REQ  = OFA_N_REQ,
    parameter int DATA_W = OFA_DATA_W,
    parameter int ADDR_W = OFA_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr0,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr1,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         sel0,
    output logic [ADDR_W-1:0]         sel1,
    input  logic [DATA_W-1:0]         rf_q0,
    input  logic [DATA_W-1:0]         rf_q1,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_data0,
    output logic [DATA_W-1:0]         rsp_data1,
    output logic                      busy
);

    localparam int ID_W = $clog2(N_REQ);

    ofa_state_e        state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [ADDR_W-1:0] sel0_q, sel1_q;
    logic [ADDR_W-1:0] sel0_d, sel1_d;
    logic              valid_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] data0_q, data1_q;
    logic [N_REQ-1:0]  win_oh;
    logic [ID_W-1:0]   win_idx;

`ifdef OFA_ROUND_ROBIN_EN
    logic [ID_W-1:0]   ptr_q, ptr_d;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req),
`ifdef OFA_ROUND_ROBIN_EN
        .ptr    (ptr_q),
`endif
        .gnt_oh (win_oh),
        .idx    (win_idx)
    );

    // Winner's register indices and the pointer value after it is served
    always_comb begin
        sel0_d = req_addr0[int'(win_idx)*ADDR_W +: ADDR_W];
        sel1_d = req_addr1[int'(win_idx)*ADDR_W +: ADDR_W];
`ifdef OFA_ROUND_ROBIN_EN
        ptr_d  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
`endif
    end

    // Transaction FSM: grant, one read cycle, then hold until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel0_q  <= '0;
            sel1_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            data0_q <= '0;
            data1_q <= '0;
`ifdef OFA_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q   <= win_oh;
                        id_q    <= win_idx;
                        sel0_q  <= sel0_d;
                        sel1_q  <= sel1_d;
                        state_q <= READ;
                    end
                end
                READ: begin
                    data0_q <= rf_q0;
                    data1_q <= rf_q1;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
`ifdef OFA_ROUND_ROBIN_EN
                        ptr_q   <= ptr_d;
`endif
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel0      = sel0_q;
    assign sel1      = sel1_q;
    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_data0 = data0_q;
    assign rsp_data1 = data1_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_operand_fetch_arbiter.sv
// Self-checking bench for operand_fetch_arbiter (N_REQ=3).
// Reference model follows OFA_ROUND_ROBIN_EN when defined.
module tb_operand_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [8:0]  req_addr0 = '0;
    logic [8:0]  req_addr1 = '0;
    logic [2:0]  gnt;
    logic [2:0]  sel0, sel1;
    logic [15:0] rf_q0, rf_q1;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data0, rsp_data1;
    logic        busy;

    logic [15:0] rf [8];
    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    // Register file read mux model
    assign rf_q0 = rf[sel0];
    assign rf_q1 = rf[sel1];

    operand_fetch_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .gnt       (gnt),
        .sel0      (sel0),
        .sel1      (sel1),
        .rf_q0     (rf_q0),
        .rf_q1     (rf_q1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data0 (rsp_data0),
        .rsp_data1 (rsp_data1),
        .busy      (busy)
    );

    // Winner by the priority rule, given a request mask and pointer
    function automatic int model_pick(logic [2:0] m, int p);
`ifdef OFA_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++)
            if (m[(p + k) % 3]) return (p + k) % 3;
`else
        for (int k = 0; k < 3; k++)
            if (m[k]) return k;
`endif
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({gnt, sel0, sel1, rsp_valid, rsp_id, rsp_data0, rsp_data1, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_init: got gnt=%b sel=%0d/%0d v=%b busy=%b want all 0",
                     gnt, sel0, sel1, rsp_valid, busy);
        end
        req = 3'b111;
        req_addr0 = {3'd1, 3'd2, 3'd5};
        req_addr1 = {3'd3, 3'd4, 3'd6};
        @(negedge clk);
        n_cmp++;
        if (gnt !== 3'b001 || sel0 !== 3'd5) begin
            n_bad++;
            $display("FAIL reset_pregnt: got gnt=%b sel0=%0d want 001/5", gnt, sel0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, sel0, sel1, rsp_valid, rsp_id, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got gnt=%b sel=%0d/%0d busy=%b want 0",
                     gnt, sel0, sel1, busy);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (gnt !== 3'b000 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: got gnt=%b busy=%b want 000/0", gnt, busy);
            end
        end
        rst = 1'b0;
        req = '0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        rf[3] = 16'h1234;
        rf[5] = 16'hABCD;
        rsp_ready = 1'b1;
        req_addr0 = {3'd0, 3'd3, 3'd0};
        req_addr1 = {3'd0, 3'd5, 3'd0};
        req = 3'b010;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 3'b010 || sel0 !== 3'd3 || sel1 !== 3'd5 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_gnt: got gnt=%b sel=%0d/%0d v=%b want 010 3/5 0",
                     gnt, sel0, sel1, rsp_valid);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data0 !== 16'h1234 || rsp_data1 !== 16'hABCD || rsp_id !== 2'd1) begin
            n_bad++;
            $display("FAIL single_rsp: got v=%b d=%h/%h id=%0d want 1 1234/abcd 1",
                     rsp_valid, rsp_data0, rsp_data1, rsp_id);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got v=%b busy=%b want 0/0", rsp_valid, busy);
        end
        m_ptr = 2;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req = 3'b010;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rf[3] = 16'($urandom) | 16'h0001;
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data0 !== 16'h1234 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold: got v=%b d0=%h busy=%b want 1 1234 1",
                         rsp_valid, rsp_data0, busy);
            end
        end
        rf[3] = 16'h1234;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accept: got v=%b busy=%b want 0/0", rsp_valid, busy);
        end
        m_ptr = 2;
    endtask

    task automatic test_contention();
        int exp_order [4];
`ifdef OFA_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        do_reset();
        rsp_ready = 1'b1;
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            bit seen = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                @(negedge clk);
                if (gnt !== 3'b000) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || gnt !== 3'(1 << exp_order[t])) begin
                n_bad++;
                $display("FAIL contention_%0d: got gnt=%b want %b", t, gnt,
                         3'(1 << exp_order[t]));
            end
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_order[t])) begin
                n_bad++;
                $display("FAIL contention_id%0d: got v=%b id=%0d want 1/%0d",
                         t, rsp_valid, rsp_id, exp_order[t]);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
        m_ptr = (exp_order[3] + 1) % 3;
    endtask

    task automatic test_same_reg();
        rf[7] = 16'hFFFF;
        rsp_ready = 1'b1;
        req_addr0 = {3'd0, 3'd0, 3'd7};
        req_addr1 = {3'd0, 3'd0, 3'd7};
        req = 3'b001;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 3'b001 || sel0 !== 3'd7 || sel1 !== 3'd7) begin
            n_bad++;
            $display("FAIL same_sel: got gnt=%b sel=%0d/%0d want 001 7/7", gnt, sel0, sel1);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data0 !== 16'hFFFF || rsp_data1 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL same_data: got v=%b d=%h/%h want 1 ffff/ffff",
                     rsp_valid, rsp_data0, rsp_data1);
        end
        @(negedge clk);
        m_ptr = 1;
    endtask

    task automatic test_abort();
        do_reset();
        rsp_ready = 1'b1;
        req_addr0 = {3'd1, 3'd2, 3'd0};
        req_addr1 = {3'd6, 3'd4, 3'd0};
        req = 3'b010;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        req = 3'b100;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 3'b100) begin
            n_bad++;
            $display("FAIL abort_gnt: got %b want 100", gnt);
        end
        req = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data0 !== 16'h0) begin
            n_bad++;
            $display("FAIL abort_async: got v=%b busy=%b d0=%h want 0 0 0",
                     rsp_valid, busy, rsp_data0);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        rf[1] = 16'h5A5A;
        rf[6] = 16'hC3C3;
        req_addr0 = {3'd0, 3'd1, 3'd0};
        req_addr1 = {3'd0, 3'd6, 3'd0};
        rsp_ready = 1'b1;
        req = 3'b110;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 3'(1 << model_pick(3'b110, m_ptr))) begin
            n_bad++;
            $display("FAIL abort_regnt: got %b want %b", gnt, 3'(1 << model_pick(3'b110, m_ptr)));
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data0 !== 16'h5A5A || rsp_data1 !== 16'hC3C3) begin
            n_bad++;
            $display("FAIL abort_rsp: got v=%b id=%0d d=%h/%h want 1 1 5a5a/c3c3",
                     rsp_valid, rsp_id, rsp_data0, rsp_data1);
        end
        @(negedge clk);
        m_ptr = 2;
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic [2:0] m;
            int w, dly;
            logic [2:0] a0, a1;
            bit seen = 1'b0;
            for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
            m = 3'($urandom_range(1, 7));
            req_addr0 = 9'($urandom);
            req_addr1 = 9'($urandom);
            dly = $urandom_range(0, 3);
            w = model_pick(m, m_ptr);
            a0 = req_addr0[w*3 +: 3];
            a1 = req_addr1[w*3 +: 3];
            rsp_ready = 1'b0;
            req = m;
            for (int c = 0; c < 4 && !seen; c++) begin
                @(negedge clk);
                if (gnt !== 3'b000) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || gnt !== 3'(1 << w) || sel0 !== a0 || sel1 !== a1) begin
                n_bad++;
                $display("FAIL rand_gnt%0d: got gnt=%b sel=%0d/%0d want %b %0d/%0d",
                         t, gnt, sel0, sel1, 3'(1 << w), a0, a1);
            end
            req = '0;
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) || rsp_data0 !== rf[a0] || rsp_data1 !== rf[a1]) begin
                n_bad++;
                $display("FAIL rand_rsp%0d: got v=%b id=%0d d=%h/%h want 1 %0d %h/%h",
                         t, rsp_valid, rsp_id, rsp_data0, rsp_data1, w, rf[a0], rf[a1]);
            end
            for (int d = 0; d < dly; d++) begin
                @(negedge clk);
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_data1 !== rf[a1]) begin
                    n_bad++;
                    $display("FAIL rand_hold%0d: got v=%b d1=%h want 1 %h",
                             t, rsp_valid, rsp_data1, rf[a1]);
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_done%0d: got v=%b busy=%b want 0/0", t, rsp_valid, busy);
            end
            m_ptr = (w + 1) % 3;
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 8; r++) rf[r] = 16'(r * 16'h1111);
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_same_reg();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
